// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared constants for the write-back end of the pipeline: register file
//   geometry, default retired-writeback counter width, and the bit layout of
//   the 20-bit MEM output bundle ({wb, dst[2:0], data[15:0]}). The memory
//   unit and hazard unit use the same field positions.
package writeback_stage_pkg;

  localparam int DATA_W       = 16;
  localparam int REG_CNT      = 8;
  localparam int ADDR_W       = 3;
  localparam int RETIRE_CNT_W = 16;

  // MEM bundle layout
  localparam int MEM_W   = 20;
  localparam int WB_BIT  = 19;
  localparam int DST_HI  = 18;
  localparam int DST_LO  = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  // Assemble a MEM bundle from its fields.
  function automatic logic [MEM_W-1:0] pack_mem(input logic              wb,
                                                 input logic [ADDR_W-1:0] dst,
                                                 input logic [DATA_W-1:0] data);
    return {wb, dst, data};
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundles the signals around the write-back stage:
//     mem_output, mem_stall, flush : MEM bundle and bubble controls in
//     rd_addr1/2, rd_data1/2       : decode-stage read ports
//     wb_en, wb_dst, wb_data       : MEM/WB contents for EX forwarding
//     retire_cnt                   : committed register writes since reset
//   master = surrounding pipeline / bench, slave = writeback_stage.
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int CNT_W = RETIRE_CNT_W
) ();

  logic [MEM_W-1:0]  mem_output;
  logic              mem_stall;
  logic              flush;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output mem_output, mem_stall, flush, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wb_en, wb_dst, wb_data, retire_cnt
  );

  modport slave (
    input  mem_output, mem_stall, flush, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wb_en, wb_dst, wb_data, retire_cnt
  );

endinterface

// File: rtl/writeback_stage_reg_file.sv
// writeback_stage_reg_file
//   8x16 general register file: one synchronous write port, two
//   combinational read ports with write-through bypass, async active-high
//   reset clearing every register. Register 0 is an ordinary register.
//   Ports: clk, rst, we/waddr/wdata (write), raddr1/2 -> rdata1/2 (read).
module writeback_stage_reg_file
  import writeback_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_r [REG_CNT];

  // Register array: cleared on reset, written on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (we) begin
        regs_r[waddr] <= wdata;
      end
    end
  end

  // Read ports: a pending write to the addressed register is returned
  // directly so decode sees it one cycle before it lands in the array.
  always_comb begin
    rdata1 = regs_r[raddr1];
    rdata2 = regs_r[raddr2];
    if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_r[raddr1];
    end
    if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Captures the MEM bundle into the MEM/WB register
//   (a bubble when stalled or flushed), commits it to the register file on
//   the following edge, and counts committed writes with a saturating
//   counter.
//   Ports: clk, rst (async, active high), bus (writeback_stage_if.slave):
//   mem_output/mem_stall/flush in, rd_addr1/2 -> rd_data1/2,
//   wb_en/wb_dst/wb_data and retire_cnt out.
//   CNT_W must match the CNT_W of the connected interface.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int CNT_W = RETIRE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              bubble_s;
  logic              wb_en_r;
  logic [ADDR_W-1:0] wb_dst_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic [CNT_W-1:0]  retire_cnt_nxt_s;

  // Stall and flush are equivalent here: either one turns the capture into a bubble.
  assign bubble_s = bus.flush | bus.mem_stall;

  // MEM/WB register; dst/data load even for bubbles so the contents stay deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_r   <= 1'b0;
      wb_dst_r  <= {ADDR_W{1'b0}};
      wb_data_r <= {DATA_W{1'b0}};
    end else begin
      wb_en_r   <= bus.mem_output[WB_BIT] & ~bubble_s;
      wb_dst_r  <= bus.mem_output[DST_HI:DST_LO];
      wb_data_r <= bus.mem_output[DATA_HI:DATA_LO];
    end
  end

  // Retired-writeback count: one per committing entry, holding at all-ones.
  always_comb begin
    retire_cnt_nxt_s = retire_cnt_r;
    if (wb_en_r && (retire_cnt_r != CNT_MAX)) begin
      retire_cnt_nxt_s = retire_cnt_r + CNT_ONE;
    end else begin
      retire_cnt_nxt_s = retire_cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else begin
      retire_cnt_r <= retire_cnt_nxt_s;
    end
  end

  writeback_stage_reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en_r),
    .waddr  (wb_dst_r),
    .wdata  (wb_data_r),
    .raddr1 (bus.rd_addr1),
    .raddr2 (bus.rd_addr2),
    .rdata1 (bus.rd_data1),
    .rdata2 (bus.rd_data2)
  );

  assign bus.wb_en      = wb_en_r;
  assign bus.wb_dst     = wb_dst_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Directed-vector bench for writeback_stage. A default instance (16-bit
//   counter) and a second instance with a 4-bit counter share the same
//   stimulus; the small one is used for the saturation vectors.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk;
  logic rst;

  writeback_stage_if #(.CNT_W(16)) bus ();
  writeback_stage_if #(.CNT_W(4))  bus_sat ();

  writeback_stage #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  writeback_stage #(.CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat.slave)
  );

  assign bus_sat.mem_output = bus.mem_output;
  assign bus_sat.mem_stall  = bus.mem_stall;
  assign bus_sat.flush      = bus.flush;
  assign bus_sat.rd_addr1   = bus.rd_addr1;
  assign bus_sat.rd_addr2   = bus.rd_addr2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled afterwards.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic wb, input logic [2:0] dst, input logic [15:0] data);
    bus.mem_output = pack_mem(wb, dst, data);
  endtask

  task automatic set_rd(input logic [2:0] a1, input logic [2:0] a2);
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_output = 20'h00000;
    bus.mem_stall  = 1'b0;
    bus.flush      = 1'b0;
    bus.rd_addr1   = 3'd0;
    bus.rd_addr2   = 3'd0;
    cyc();
    cyc();
    rst = 1'b0;
    set_rd(3'd5, 3'd7);
    check_vec("reset_wb_en",  {31'd0, bus.wb_en}, 32'd0);
    check_vec("reset_retire", {16'd0, bus.retire_cnt}, 32'd0);
    check_vec("reset_rd1",    {16'd0, bus.rd_data1}, 32'd0);
    check_vec("reset_rd2",    {16'd0, bus.rd_data2}, 32'd0);

    // Basic write to r5
    present(1'b1, 3'd5, 16'hBEEF);
    cyc();
    check_vec("basic_wb_en",   {31'd0, bus.wb_en}, 32'd1);
    check_vec("basic_wb_dst",  {29'd0, bus.wb_dst}, 32'd5);
    check_vec("basic_bypass",  {16'd0, bus.rd_data1}, 32'h0000BEEF);
    check_vec("basic_retire0", {16'd0, bus.retire_cnt}, 32'd0);
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    check_vec("basic_wb_en_off", {31'd0, bus.wb_en}, 32'd0);
    check_vec("basic_reg5",      {16'd0, bus.rd_data1}, 32'h0000BEEF);
    check_vec("basic_retire1",   {16'd0, bus.retire_cnt}, 32'd1);

    // Stall two cycles, flush one, then both together
    present(1'b1, 3'd5, 16'h1234);
    bus.mem_stall = 1'b1;
    cyc();
    check_vec("stall1_wb_en", {31'd0, bus.wb_en}, 32'd0);
    cyc();
    check_vec("stall2_wb_en", {31'd0, bus.wb_en}, 32'd0);
    bus.mem_stall = 1'b0;
    bus.flush     = 1'b1;
    cyc();
    check_vec("flush_wb_en", {31'd0, bus.wb_en}, 32'd0);
    check_vec("flush_rd5",   {16'd0, bus.rd_data1}, 32'h0000BEEF);
    bus.mem_stall = 1'b1;
    cyc();
    check_vec("stallflush_wb_en", {31'd0, bus.wb_en}, 32'd0);
    bus.mem_stall = 1'b0;
    bus.flush     = 1'b0;
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    check_vec("stall_reg5",   {16'd0, bus.rd_data1}, 32'h0000BEEF);
    check_vec("stall_retire", {16'd0, bus.retire_cnt}, 32'd1);

    // Back-to-back writes to r2
    set_rd(3'd5, 3'd2);
    present(1'b1, 3'd2, 16'h1111);
    cyc();
    check_vec("b2b_first", {16'd0, bus.rd_data2}, 32'h00001111);
    present(1'b1, 3'd2, 16'h2222);
    cyc();
    check_vec("b2b_second",  {16'd0, bus.rd_data2}, 32'h00002222);
    check_vec("b2b_retire2", {16'd0, bus.retire_cnt}, 32'd2);
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    check_vec("b2b_reg2",    {16'd0, bus.rd_data2}, 32'h00002222);
    check_vec("b2b_retire3", {16'd0, bus.retire_cnt}, 32'd3);

    // Dual-read collision on r3
    set_rd(3'd3, 3'd3);
    present(1'b1, 3'd3, 16'h0042);
    cyc();
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    check_vec("dual_stored1", {16'd0, bus.rd_data1}, 32'h00000042);
    present(1'b1, 3'd3, 16'h00A5);
    bus.flush = 1'b1;
    cyc();
    // MEM/WB holds dst 3 / 0x00A5 but not enabled: must read the array
    check_vec("dual_noen_rd1", {16'd0, bus.rd_data1}, 32'h00000042);
    check_vec("dual_noen_rd2", {16'd0, bus.rd_data2}, 32'h00000042);
    bus.flush = 1'b0;
    cyc();
    check_vec("dual_byp_rd1", {16'd0, bus.rd_data1}, 32'h000000A5);
    check_vec("dual_byp_rd2", {16'd0, bus.rd_data2}, 32'h000000A5);
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    check_vec("dual_reg3",    {16'd0, bus.rd_data2}, 32'h000000A5);

    // Register 0 is writable
    present(1'b1, 3'd0, 16'h0F0F);
    cyc();
    present(1'b0, 3'd1, 16'hFFFF);
    cyc();
    set_rd(3'd0, 3'd1);
    check_vec("reg0_write",  {16'd0, bus.rd_data1}, 32'h00000F0F);
    check_vec("reg1_intact", {16'd0, bus.rd_data2}, 32'h00000000);
    check_vec("retire6",     {16'd0, bus.retire_cnt}, 32'd6);

    // Reset mid-run with a write pending to r4
    present(1'b1, 3'd4, 16'hCAFE);
    cyc();
    check_vec("prerst_wb_en", {31'd0, bus.wb_en}, 32'd1);
    set_rd(3'd5, 3'd4);
    rst = 1'b1;
    #1;
    check_vec("rst_wb_en",  {31'd0, bus.wb_en}, 32'd0);
    check_vec("rst_retire", {16'd0, bus.retire_cnt}, 32'd0);
    check_vec("rst_rd5",    {16'd0, bus.rd_data1}, 32'd0);
    check_vec("rst_rd4",    {16'd0, bus.rd_data2}, 32'd0);
    present(1'b0, 3'd0, 16'h0000);
    cyc();
    rst = 1'b0;
    cyc();
    check_vec("postrst_rd4",    {16'd0, bus.rd_data2}, 32'd0);
    check_vec("postrst_retire", {16'd0, bus.retire_cnt}, 32'd0);

    // 17 consecutive writes: 4-bit counter saturates at 15
    for (int i = 0; i < 17; i++) begin
      present(1'b1, 3'd1, 16'(i + 1));
      cyc();
    end
    present(1'b0, 3'd1, 16'hFFFF);
    cyc();
    check_vec("sat_hold",     {28'd0, bus_sat.retire_cnt}, 32'd15);
    check_vec("wide_count17", {16'd0, bus.retire_cnt}, 32'd17);
    set_rd(3'd1, 3'd1);
    check_vec("sat_last_data", {16'd0, bus.rd_data1}, 32'd17);
    cyc();
    cyc();
    check_vec("sat_bubbles",  {28'd0, bus_sat.retire_cnt}, 32'd15);
    check_vec("wide_bubbles", {16'd0, bus.retire_cnt}, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory unit. It consumes the memory unit's 20-bit MEM output bundle: wb flag, 3-bit destination and 16-bit data.
- It latches that bundle into the MEM/WB pipeline register and commits it to the 8x16 general register file one cycle later.
- It serves the decode stage's two register read ports, with write-through bypass.
- It keeps a retired-writeback counter for debug and performance visibility.

Parameters:
DATA_W, 16, data width of a register and of the MEM data field
REG_CNT, 8, number of general registers
ADDR_W, 3, register index width (log2 REG_CNT)
CNT_W, 16, width of the retired-writeback counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
mem_output  in  20  MEM bundle: [19]=wb, [18:16]=dst, [15:0]=data
mem_stall  in  1  memory unit multi-cycle stall (Stall_Signal); current bundle is not a completed instruction
flush  in  1  squash: bundle presented this cycle must not commit
rd_addr1  in  ADDR_W  decode read port 1 index
rd_addr2  in  ADDR_W  decode read port 2 index
rd_data1  out  DATA_W  register value for rd_addr1 (bypassed)
rd_data2  out  DATA_W  register value for rd_addr2 (bypassed)
wb_en  out  1  MEM/WB register holds a committing write
wb_dst  out  ADDR_W  MEM/WB destination (for hazard/forward logic in EX)
wb_data  out  DATA_W  MEM/WB data (forward source for EX)
retire_cnt  out  CNT_W  number of register writes committed since reset

Behaviour:
- Reset (async, rst=1): wb_en=0, wb_dst=0, wb_data=0, all REG_CNT registers=0, retire_cnt=0. rd_data1/2 therefore read 0. Reset asserted mid-operation discards the in-flight MEM/WB entry immediately; no write commits on the edge where rst is high.
- Capture (every rising edge, rst=0):
  - If flush=1 or mem_stall=1, load a bubble: wb_en<=0. wb_dst and wb_data still load from mem_output (don't-care, but deterministic).
  - Otherwise load wb_en<=mem_output[19], wb_dst<=mem_output[18:16], wb_data<=mem_output[15:0].
  - flush and mem_stall together: a single bubble results; no priority difference.
- Commit:
  - On the rising edge following capture, if wb_en=1, reg[wb_dst] <= wb_data and retire_cnt increments.
  - Total latency: bundle presented in cycle N, architecturally visible in the register array after edge N+2, and visible at rd_data via bypass during cycle N+1.
- Read ports (combinational):
  - rd_dataK = wb_data if wb_en=1 and rd_addrK==wb_dst; else reg[rd_addrK].
  - Both ports may address the same register or the same wb_dst simultaneously; both return identical values.
- Back-to-back writes to the same dst: the later entry wins. Capture and commit overlap in one edge, so the commit uses the old MEM/WB contents and the new entry is loaded; the bypass then shows the newer value.
- retire_cnt saturates at 2^CNT_W-1 and does not wrap. Bubbles never count.
- Register 0 is a normal writable register (no hardwired zero).
- No handshake back-pressure: the stage always accepts. Stall is honoured only by inserting bubbles, since the memory unit holds its bundle stable while stalling.

Decomposition:
- Shared package: DATA_W/ADDR_W/REG_CNT constants and MEM bundle field positions (WB_BIT=19, DST_HI=18, DST_LO=16, DATA_HI=15, DATA_LO=0). These are reused by memory_unit and the hazard unit.
- One sub-module: reg_file. It contains the register array, one synchronous write port, two async read ports, async reset, and the write-through bypass.
- writeback_stage instantiates reg_file and holds the MEM/WB register and the counter.

Test Plan:
- Reset: rst=1 mid-run with wb_en=1 pending -> wb_en=0, rd_data1 for any addr=0, retire_cnt=0 immediately (before next edge).
- Basic write: mem_output={1,3'd5,16'hBEEF}, no stall/flush -> next cycle wb_en=1, wb_dst=5, rd_data1(addr5)=BEEF via bypass. One edge later reg[5]=BEEF, wb_en=0 (if followed by a bubble), retire_cnt=1.
- Stall/flush: same bundle with mem_stall=1 for 2 cycles, then with flush=1 -> wb_en stays 0, reg[5] unchanged, retire_cnt unchanged.
- Back-to-back same dst: {1,2,0x1111} then {1,2,0x2222} -> rd_data2(addr2) shows 1111 then 2222. Final reg[2]=2222, retire_cnt=+2.
- Dual read collision: both rd_addr=3 while wb_dst=3, wb_en=1, wb_data=0x00A5 -> rd_data1=rd_data2=00A5. With wb_en=0 both return the stored reg[3].
- Saturation (CNT_W overridden to 4): 17 consecutive valid writes -> retire_cnt holds at 15. wb=0 bundles leave it unchanged.
